// File: rtl/map_state_memory_pkg.sv
// map_defs: shared cell codes, FSM states and grid helpers for the Pacman map
package map_defs;
  localparam int GRID = 21;
  localparam int TYPE_W = 4;
  localparam int CELLS = GRID * GRID;
  localparam int IDX_W = 9;
  localparam int CNT_W = 9;
  localparam logic [TYPE_W-1:0] CELL_EMPTY = 4'd0;
  localparam logic [TYPE_W-1:0] CELL_WALL = 4'd1;
  localparam logic [TYPE_W-1:0] CELL_PELLET = 4'd2;
  localparam logic [TYPE_W-1:0] CELL_POWER = 4'd3;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR_FETCH, ST_WR_COMMIT} state_e;
  function automatic logic [IDX_W-1:0] cell_index(input logic [4:0] x, input logic [4:0] y);
    return IDX_W'(y * GRID + x);
  endfunction
  function automatic logic in_grid(input logic [4:0] x, input logic [4:0] y);
    return x < 5'(GRID) && y < 5'(GRID);
  endfunction
  function automatic logic is_edible(input logic [TYPE_W-1:0] t);
    return t == CELL_PELLET || t == CELL_POWER;
  endfunction
  function automatic logic [TYPE_W-1:0] cell_default(input logic [4:0] x, input logic [4:0] y);
    logic bx, by, cx, cy;
    bx = x == 5'd0 || x == 5'(GRID - 1);
    by = y == 5'd0 || y == 5'(GRID - 1);
    cx = x == 5'd1 || x == 5'(GRID - 2);
    cy = y == 5'd1 || y == 5'(GRID - 2);
    return (bx || by) ? CELL_WALL : (cx && cy) ? CELL_POWER : CELL_PELLET;
  endfunction
endpackage

// File: rtl/map_state_memory_layout.sv
// map_default_layout: combinational default cell type for a grid coordinate
module map_default_layout
  import map_defs::*;
(
  input  logic [4:0]        x_i,
  input  logic [4:0]        y_i,
  output logic [TYPE_W-1:0] type_o
);
  assign type_o = cell_default(x_i, y_i);
endmodule

// File: rtl/map_state_memory.sv
// map_state_memory: live 21x21 map store with read port, handshaked writes and pellet tracking
module map_state_memory
  import map_defs::*;
(
  input  logic              clock_50,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [4:0]        rd_x,
  input  logic [4:0]        rd_y,
  output logic [TYPE_W-1:0] rd_type,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [4:0]        wr_x,
  input  logic [4:0]        wr_y,
  input  logic [TYPE_W-1:0] wr_type,
  output logic              wr_ack,
  output logic              ready,
  output logic [CNT_W-1:0]  pellet_count,
  output logic              all_eaten
);
  logic [TYPE_W-1:0] mem [CELLS];
  state_e state_q, state_d;
  logic [4:0] ix_q, ix_d, iy_q, iy_d, wx_q, wx_d, wy_q, wy_d;
  logic [TYPE_W-1:0] wt_q, wt_d, old_q, old_d, rt_q, rt_d, def_type, mem_wd;
  logic ready_q, ready_d, ack_q, ack_d, rv_q, rv_d, mem_we, w_in, last_col;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
  logic [IDX_W-1:0] mem_wa, w_idx;

  map_default_layout u_layout (.x_i(ix_q), .y_i(iy_q), .type_o(def_type));

  assign w_in = in_grid(wx_q, wy_q);
  assign w_idx = cell_index(wx_q, wy_q);
  assign last_col = ix_q == 5'(GRID - 1);
  assign cnt_inc = cnt_q == CNT_W'(CELLS) ? cnt_q : cnt_q + 1'b1;
  assign cnt_dec = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
  assign rv_d = rd_en && ready_q;
  // the read sees the array before any same-edge commit, giving read-before-write
  assign rt_d = !rv_d ? rt_q : in_grid(rd_x, rd_y) ? mem[cell_index(rd_x, rd_y)] : CELL_WALL;

  always_comb begin
    state_d = state_q;
    ix_d = ix_q;
    iy_d = iy_q;
    wx_d = wx_q;
    wy_d = wy_q;
    wt_d = wt_q;
    old_d = old_q;
    ready_d = ready_q;
    cnt_d = cnt_q;
    ack_d = 1'b0;
    mem_we = 1'b0;
    mem_wa = w_idx;
    mem_wd = wt_q;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        mem_wa = cell_index(ix_q, iy_q);
        mem_wd = def_type;
        cnt_d = is_edible(def_type) ? cnt_inc : cnt_q;
        ix_d = last_col ? 5'd0 : ix_q + 5'd1;
        iy_d = last_col ? iy_q + 5'd1 : iy_q;
        if (last_col && iy_q == 5'(GRID - 1)) begin
          iy_d = 5'd0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // a request still held during the ack cycle is the one just served
        if (wr_req && !ack_q) begin
          wx_d = wr_x;
          wy_d = wr_y;
          wt_d = wr_type;
          state_d = ST_WR_FETCH;
        end
      end
      ST_WR_FETCH: begin
        old_d = w_in ? mem[w_idx] : old_q;
        state_d = ST_WR_COMMIT;
      end
      ST_WR_COMMIT: begin
        mem_we = w_in;
        ack_d = 1'b1;
        state_d = ST_IDLE;
        cnt_d = !w_in || is_edible(old_q) == is_edible(wt_q) ? cnt_q :
                is_edible(wt_q) ? cnt_inc : cnt_dec;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      ix_q <= '0;
      iy_q <= '0;
      wx_q <= '0;
      wy_q <= '0;
      wt_q <= '0;
      old_q <= '0;
      ready_q <= 1'b0;
      cnt_q <= '0;
      ack_q <= 1'b0;
      rv_q <= 1'b0;
      rt_q <= '0;
    end else begin
      state_q <= state_d;
      ix_q <= ix_d;
      iy_q <= iy_d;
      wx_q <= wx_d;
      wy_q <= wy_d;
      wt_q <= wt_d;
      old_q <= old_d;
      ready_q <= ready_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      rv_q <= rv_d;
      rt_q <= rt_d;
    end
  end

  always_ff @(posedge clock_50) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rd_type = rt_q;
  assign rd_valid = rv_q;
  assign wr_ack = ack_q;
  assign ready = ready_q;
  assign pellet_count = cnt_q;
  assign all_eaten = ready_q && cnt_q == '0;
endmodule

// File: tb/tb_map_state_memory.sv
// tb_map_state_memory: scenario tasks with a read scoreboard and a reference map model
module tb_map_state_memory;
  logic clock_50 = 1'b0;
  logic reset = 1'b1;
  logic rd_en = 1'b0;
  logic wr_req = 1'b0;
  logic [4:0] rd_x = '0, rd_y = '0, wr_x = '0, wr_y = '0;
  logic [3:0] wr_type = '0;
  logic [3:0] rd_type;
  logic rd_valid, wr_ack, ready, all_eaten;
  logic [8:0] pellet_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_map [21][21];
  int exp_cnt;
  logic [3:0] exp_q [$];

  map_state_memory dut (
    .clock_50(clock_50), .reset(reset),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_type(rd_type), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type), .wr_ack(wr_ack),
    .ready(ready), .pellet_count(pellet_count), .all_eaten(all_eaten)
  );

  always #5 clock_50 = ~clock_50;

  function automatic logic [3:0] ref_default(int x, int y);
    if (x == 0 || x == 20 || y == 0 || y == 20) return 4'd1;
    if ((x == 1 || x == 19) && (y == 1 || y == 19)) return 4'd3;
    return 4'd2;
  endfunction

  function automatic bit edible(logic [3:0] t);
    return t == 4'd2 || t == 4'd3;
  endfunction

  task automatic model_init();
    exp_cnt = 0;
    for (int x = 0; x < 21; x++)
      for (int y = 0; y < 21; y++) begin
        exp_map[x][y] = ref_default(x, y);
        if (edible(exp_map[x][y])) exp_cnt++;
      end
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_read(int x, int y);
    logic [3:0] e;
    rd_en = 1'b1;
    rd_x = 5'(x);
    rd_y = 5'(y);
    exp_q.push_back((x < 21 && y < 21) ? exp_map[x][y] : 4'd1);
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_valid (%0d,%0d): got %b want 1", x, y, rd_valid);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL read_sb (%0d,%0d): scoreboard empty", x, y);
    end else begin
      e = exp_q.pop_front();
      if (rd_type !== e) begin
        errors++;
        $display("FAIL read_type (%0d,%0d): got %0d want %0d", x, y, rd_type, e);
      end
    end
  endtask

  task automatic model_write(int x, int y, logic [3:0] t);
    if (x < 21 && y < 21) begin
      if (edible(exp_map[x][y]) && !edible(t) && exp_cnt > 0) exp_cnt--;
      else if (!edible(exp_map[x][y]) && edible(t) && exp_cnt < 441) exp_cnt++;
      exp_map[x][y] = t;
    end
  endtask

  task automatic do_write(int x, int y, logic [3:0] t);
    int lat;
    wr_req = 1'b1;
    wr_x = 5'(x);
    wr_y = 5'(y);
    wr_type = t;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (wr_ack) begin
        lat = i;
        break;
      end
    end
    wr_req = 1'b0;
    model_write(x, y, t);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL write_latency (%0d,%0d): got %0d want 3", x, y, lat);
    end
    checks++;
    if (pellet_count !== 9'(exp_cnt)) begin
      errors++;
      $display("FAIL write_count (%0d,%0d): got %0d want %0d", x, y, pellet_count, exp_cnt);
    end
    tick();
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse (%0d,%0d): got %b want 0", x, y, wr_ack);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ready, rd_valid, wr_ack, rd_type, pellet_count} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got r%b v%b a%b t%0d c%0d want all 0", ready, rd_valid, wr_ack, rd_type, pellet_count);
    end
    tick();
    tick();
  endtask

  task automatic test_init();
    int n;
    bit bad;
    reset = 1'b1;
    n = -1;
    bad = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      rd_en = i <= 20;
      wr_req = i <= 20;
      wr_x = 5'd10;
      wr_y = 5'd10;
      wr_type = 4'd0;
      tick();
      if (rd_valid || wr_ack) bad = 1'b1;
      if (ready) begin
        n = i;
        break;
      end
    end
    rd_en = 1'b0;
    wr_req = 1'b0;
    model_init();
    checks++;
    if (n != 441) begin
      errors++;
      $display("FAIL init_cycles: got %0d want 441", n);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL init_ignores_ports: got rd_valid/wr_ack during init want none");
    end
    checks++;
    if (pellet_count !== 9'd361 || exp_cnt != 361) begin
      errors++;
      $display("FAIL init_count: got %0d want 361 (model %0d)", pellet_count, exp_cnt);
    end
    checks++;
    if (all_eaten !== 1'b0) begin
      errors++;
      $display("FAIL init_all_eaten: got %b want 0", all_eaten);
    end
  endtask

  task automatic test_read();
    int xs [3] = '{19, 0, 7};
    int ys [3] = '{19, 20, 4};
    logic [3:0] e;
    do_read(0, 5);
    do_read(1, 1);
    do_read(10, 10);
    do_read(25, 3);
    do_read(3, 25);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      rd_x = 5'(xs[i]);
      rd_y = 5'(ys[i]);
      exp_q.push_back(exp_map[xs[i]][ys[i]]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_type !== e) begin
        errors++;
        $display("FAIL b2b_read %0d: got v%b t%0d want v1 t%0d", i, rd_valid, rd_type, e);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_write();
    do_write(10, 10, 4'd0);
    checks++;
    if (pellet_count !== 9'd360) begin
      errors++;
      $display("FAIL eat_10_10: got %0d want 360", pellet_count);
    end
    do_read(10, 10);
    do_write(10, 10, 4'd2);
    do_write(0, 0, 4'd0);
    do_read(0, 0);
    do_write(25, 3, 4'd2);
    do_write(0, 0, 4'd1);
    do_write(3, 3, 4'd2);
    do_write(4, 4, 4'd9);
    do_read(4, 4);
    do_write(4, 4, 4'd3);
    do_read(4, 4);
    checks++;
    if (pellet_count !== 9'd361) begin
      errors++;
      $display("FAIL write_restore: got %0d want 361", pellet_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    wr_req = 1'b1;
    wr_x = 5'd5;
    wr_y = 5'd5;
    wr_type = 4'd0;
    tick();
    tick();
    rd_en = 1'b1;
    rd_x = 5'd5;
    rd_y = 5'd5;
    exp_q.push_back(exp_map[5][5]);
    tick();
    rd_en = 1'b0;
    wr_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (wr_ack !== 1'b1 || rd_valid !== 1'b1 || rd_type !== e) begin
      errors++;
      $display("FAIL read_before_write: got a%b v%b t%0d want a1 v1 t%0d", wr_ack, rd_valid, rd_type, e);
    end
    model_write(5, 5, 4'd0);
    do_read(5, 5);
  endtask

  task automatic test_eat_all();
    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++)
        if (edible(exp_map[x][y])) do_write(x, y, 4'd0);
    checks++;
    if (pellet_count !== 9'd0 || all_eaten !== 1'b1) begin
      errors++;
      $display("FAIL eat_all: got c%0d e%b want c0 e1", pellet_count, all_eaten);
    end
    do_write(1, 1, 4'd0);
    do_write(0, 0, 4'd0);
    checks++;
    if (pellet_count !== 9'd0 || all_eaten !== 1'b1) begin
      errors++;
      $display("FAIL eat_floor: got c%0d e%b want c0 e1", pellet_count, all_eaten);
    end
    do_write(2, 2, 4'd3);
    checks++;
    if (all_eaten !== 1'b0) begin
      errors++;
      $display("FAIL uneaten: got %b want 0", all_eaten);
    end
  endtask

  task automatic test_reset_abort();
    int n, part;
    part = 0;
    for (int i = 0; i < 200; i++)
      if (edible(ref_default(i % 21, i / 21))) part++;
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || pellet_count !== 9'd0 || all_eaten !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got r%b c%0d e%b want 0 0 0", ready, pellet_count, all_eaten);
    end
    tick();
    reset = 1'b1;
    repeat (200) tick();
    checks++;
    if (ready !== 1'b0 || pellet_count !== 9'(part)) begin
      errors++;
      $display("FAIL init_idx200: got r%b c%0d want r0 c%0d", ready, pellet_count, part);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pellet_count !== 9'd0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_init: got c%0d r%b want 0 0", pellet_count, ready);
    end
    tick();
    reset = 1'b1;
    wait_ready(n);
    model_init();
    checks++;
    if (n != 441 || pellet_count !== 9'd361) begin
      errors++;
      $display("FAIL reinit_1: got n%0d c%0d want 441 361", n, pellet_count);
    end
    do_write(10, 10, 4'd0);
    wr_req = 1'b1;
    wr_x = 5'd11;
    wr_y = 5'd11;
    wr_type = 4'd0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (wr_ack !== 1'b0 || ready !== 1'b0 || pellet_count !== 9'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_write: got a%b r%b c%0d v%b want 0 0 0 0", wr_ack, ready, pellet_count, rd_valid);
    end
    wr_req = 1'b0;
    tick();
    reset = 1'b1;
    wait_ready(n);
    model_init();
    checks++;
    if (n != 441 || pellet_count !== 9'd361) begin
      errors++;
      $display("FAIL reinit_2: got n%0d c%0d want 441 361", n, pellet_count);
    end
    do_read(10, 10);
    do_read(11, 11);
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_write();
    test_back_to_back();
    test_eat_all();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
